// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants, frame buffer geometry and pixel type
package vga_pkg;
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int FB_COLS   = 128;
    localparam int FB_ROWS   = 64;
    localparam int COL_W     = $clog2(FB_COLS);
    localparam int ROW_W     = $clog2(FB_ROWS);

    localparam int CNT_W     = 10;

    localparam int R_W       = 4;
    localparam int G_W       = 4;
    localparam int B_W       = 4;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb12_t;
endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - raster counters with raw sync and visible flags
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACT = H_VISIBLE,
    parameter int H_FRT = H_FP,
    parameter int H_SW  = H_SYNC,
    parameter int H_BCK = H_BP,
    parameter int V_ACT = V_VISIBLE,
    parameter int V_FRT = V_FP,
    parameter int V_SW  = V_SYNC,
    parameter int V_BCK = V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             line_end,
    output logic             frame_end,
    output logic             h_visible,
    output logic             hsync_raw,
    output logic             vsync_raw
);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_ACT + H_FRT + H_SW + H_BCK - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_ACT + V_FRT + V_SW + V_BCK - 1);
    localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_ACT + H_FRT);
    localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_ACT + H_FRT + H_SW);
    localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_ACT + V_FRT);
    localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_ACT + V_FRT + V_SW);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        line_end  = (h_cnt_q == H_LAST);
        frame_end = line_end && (v_cnt_q == V_LAST);
        h_cnt_d   = line_end ? '0 : h_cnt_q + CNT_W'(1);
        v_cnt_d   = v_cnt_q;
        if (frame_end) begin
            v_cnt_d = '0;
        end else if (line_end) begin
            v_cnt_d = v_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt     = h_cnt_q;
    assign v_cnt     = v_cnt_q;
    assign h_visible = (h_cnt_q < H_ACT_C);
    assign hsync_raw = !((h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI));
    assign vsync_raw = !((v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI));
endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - upscaling frame buffer scanout with double-buffer swap in vertical blank
module vga_scanout
    import vga_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int COLOR_W  = 12,
    parameter int H_SCALE  = 5,
    parameter int V_SCALE  = 7,
    parameter int V_OFFSET = 16,
    parameter int H_ACT    = H_VISIBLE,
    parameter int H_FRT    = H_FP,
    parameter int H_SW     = H_SYNC,
    parameter int H_BCK    = H_BP,
    parameter int V_ACT    = V_VISIBLE,
    parameter int V_FRT    = V_FP,
    parameter int V_SW     = V_SYNC,
    parameter int V_BCK    = V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  read_addr,
    input  logic [COLOR_W-1:0] din,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               frame_sel,
    output logic               hsync,
    output logic               vsync,
    output logic [R_W-1:0]     vga_r,
    output logic [G_W-1:0]     vga_g,
    output logic [B_W-1:0]     vga_b,
    output logic               frame_start
);
    localparam int HS_W = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
    localparam int VS_W = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;
    localparam logic [HS_W-1:0]  HS_LAST   = HS_W'(H_SCALE - 1);
    localparam logic [VS_W-1:0]  VS_LAST   = VS_W'(V_SCALE - 1);
    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(FB_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(FB_ROWS - 1);
    localparam logic [CNT_W-1:0] IMG_W     = CNT_W'(FB_COLS * H_SCALE);
    localparam logic [CNT_W-1:0] IMG_TOP   = CNT_W'(V_OFFSET);
    localparam logic [CNT_W-1:0] IMG_END   = CNT_W'(V_OFFSET + FB_ROWS * V_SCALE);
    localparam logic [CNT_W-1:0] SWAP_LINE = CNT_W'(V_ACT);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             line_end, frame_end, h_visible, hsync_raw, vsync_raw;
    logic             v_img, in_img, swap_pt;

    logic [HS_W-1:0]   h_sub_q, h_sub_d;
    logic [VS_W-1:0]   v_sub_q, v_sub_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              frame_sel_q, frame_sel_d;
    logic              swap_ack_q, swap_ack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              img1_q, hs1_q, vs1_q, fs1_q;
    logic              img1_d, hs1_d, vs1_d, fs1_d;
    rgb12_t            rgb_q, rgb_d;
    logic              hs2_q, vs2_q, fs2_q;

    vga_timing #(
        .H_ACT(H_ACT), .H_FRT(H_FRT), .H_SW(H_SW), .H_BCK(H_BCK),
        .V_ACT(V_ACT), .V_FRT(V_FRT), .V_SW(V_SW), .V_BCK(V_BCK)
    ) u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .line_end  (line_end),
        .frame_end (frame_end),
        .h_visible (h_visible),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw)
    );

    always_comb begin
        v_img   = (v_cnt >= IMG_TOP) && (v_cnt < IMG_END);
        in_img  = v_img && h_visible && (h_cnt < IMG_W);
        swap_pt = (h_cnt == '0) && (v_cnt == SWAP_LINE);

        // Sub-counters clear on the wrap edge so they read 0 while h_cnt/v_cnt are 0.
        h_sub_d = h_sub_q;
        col_d   = col_q;
        if (line_end) begin
            h_sub_d = '0;
            col_d   = '0;
        end else if (h_visible) begin
            if (h_sub_q == HS_LAST) begin
                h_sub_d = '0;
                if (col_q != COL_MAX) col_d = col_q + COL_W'(1);
            end else begin
                h_sub_d = h_sub_q + HS_W'(1);
            end
        end

        v_sub_d = v_sub_q;
        row_d   = row_q;
        if (frame_end) begin
            v_sub_d = '0;
            row_d   = '0;
        end else if (line_end && v_img) begin
            if (v_sub_q == VS_LAST) begin
                v_sub_d = '0;
                if (row_q != ROW_MAX) row_d = row_q + ROW_W'(1);
            end else begin
                v_sub_d = v_sub_q + VS_W'(1);
            end
        end

        swap_ack_d  = swap_pt && swap_req;
        frame_sel_d = frame_sel_q ^ swap_ack_d;

        addr_d = in_img ? ADDR_W'({frame_sel_q, col_q, row_q}) : '0;
        img1_d = in_img;
        hs1_d  = hsync_raw;
        vs1_d  = vsync_raw;
        fs1_d  = (h_cnt == '0) && (v_cnt == IMG_TOP);

        rgb_d  = img1_q ? rgb12_t'(din) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_sub_q     <= '0;
            v_sub_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            frame_sel_q <= 1'b0;
            swap_ack_q  <= 1'b0;
            addr_q      <= '0;
            img1_q      <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            fs1_q       <= 1'b0;
            rgb_q       <= '0;
            hs2_q       <= 1'b1;
            vs2_q       <= 1'b1;
            fs2_q       <= 1'b0;
        end else begin
            h_sub_q     <= h_sub_d;
            v_sub_q     <= v_sub_d;
            col_q       <= col_d;
            row_q       <= row_d;
            frame_sel_q <= frame_sel_d;
            swap_ack_q  <= swap_ack_d;
            addr_q      <= addr_d;
            img1_q      <= img1_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            fs1_q       <= fs1_d;
            rgb_q       <= rgb_d;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
            fs2_q       <= fs1_q;
        end
    end

    assign read_addr   = addr_q;
    assign swap_ack    = swap_ack_q;
    assign frame_sel   = frame_sel_q;
    assign hsync       = hs2_q;
    assign vsync       = vs2_q;
    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign frame_start = fs2_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - bench for vga_scanout: full-size timing instance plus a shrunken-raster instance
module tb_vga_scanout;
    typedef struct packed {
        int hvis; int hfp; int hsw; int hbp;
        int vvis; int vfp; int vsw; int vbp;
        int hs;   int vs;  int voff;
    } cfg_t;

    cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 5, 7, 16};
    cfg_t cfg_b = '{128, 4, 8, 4, 72, 2, 2, 3, 1, 1, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n = 1'b1, rst_b_n = 1'b1;
    logic        swap_a = 1'b0, swap_b = 1'b0;
    logic [13:0] read_addr_a, read_addr_b;
    logic [11:0] din_a, din_b;
    logic        swap_ack_a, swap_ack_b, frame_sel_a, frame_sel_b;
    logic        hsync_a, hsync_b, vsync_a, vsync_b, fs_a, fs_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic [31:0] vec_a, vec_b;

    assign din_a = read_addr_a[11:0];
    assign din_b = read_addr_b[11:0];
    assign vec_a = {read_addr_a, frame_sel_a, swap_ack_a, hsync_a, vsync_a, r_a, g_a, b_a, fs_a, 1'b0};
    assign vec_b = {read_addr_b, frame_sel_b, swap_ack_b, hsync_b, vsync_b, r_b, g_b, b_b, fs_b, 1'b0};

    vga_scanout u_dut_a (
        .clk(clk), .rst_n(rst_a_n), .read_addr(read_addr_a), .din(din_a),
        .swap_req(swap_a), .swap_ack(swap_ack_a), .frame_sel(frame_sel_a),
        .hsync(hsync_a), .vsync(vsync_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .frame_start(fs_a)
    );

    vga_scanout #(
        .H_SCALE(1), .V_SCALE(1), .V_OFFSET(4),
        .H_ACT(128), .H_FRT(4), .H_SW(8), .H_BCK(4),
        .V_ACT(72), .V_FRT(2), .V_SW(2), .V_BCK(3)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_b_n), .read_addr(read_addr_b), .din(din_b),
        .swap_req(swap_b), .swap_ack(swap_ack_b), .frame_sel(frame_sel_b),
        .hsync(hsync_b), .vsync(vsync_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .frame_start(fs_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit done_a = 1'b0, done_b = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    endtask

    function automatic int htot(input cfg_t c);
        return c.hvis + c.hfp + c.hsw + c.hbp;
    endfunction

    function automatic int vtot(input cfg_t c);
        return c.vvis + c.vfp + c.vsw + c.vbp;
    endfunction

    // Address the scanout must issue for raster position p (cycles since frame start).
    function automatic logic [13:0] img_addr(input cfg_t c, input int p, input logic fsel);
        int q, h, v;
        q = p % (htot(c) * vtot(c));
        h = q % htot(c);
        v = q / htot(c);
        if (h < 128 * c.hs && v >= c.voff && v < c.voff + 64 * c.vs)
            return 14'((fsel ? 8192 : 0) + (h / c.hs) * 64 + (v - c.voff) / c.vs);
        return 14'd0;
    endfunction

    // k = clock edges since reset release; read_addr reflects position k-1, pins position k-2.
    function automatic logic [31:0] expect_vec(input cfg_t c, input int k, input logic fsel, input logic ack);
        logic [13:0] a, px;
        logic        hs, vs, fs;
        int          p, h, v;
        a = 14'd0; px = 14'd0; hs = 1'b1; vs = 1'b1; fs = 1'b0;
        if (k >= 1) a = img_addr(c, k - 1, fsel);
        if (k >= 2) begin
            p  = (k - 2) % (htot(c) * vtot(c));
            h  = p % htot(c);
            v  = p / htot(c);
            hs = !(h >= c.hvis + c.hfp && h < c.hvis + c.hfp + c.hsw);
            vs = !(v >= c.vvis + c.vfp && v < c.vvis + c.vfp + c.vsw);
            fs = (h == 0 && v == c.voff);
            px = img_addr(c, k - 2, 1'b0);
        end
        return {a, fsel, ack, hs, vs, px[11:0], fs, 1'b0};
    endfunction

    int   k_a = 0, k_b = 0;
    logic mfs_a = 1'b0, mfs_b = 1'b0, mack_a = 1'b0, mack_b = 1'b0;

    always @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            k_a = 0; mfs_a = 1'b0; mack_a = 1'b0;
        end else begin
            mack_a = ((k_a % (htot(cfg_a) * vtot(cfg_a))) == cfg_a.vvis * htot(cfg_a)) && swap_a;
            if (mack_a) mfs_a = ~mfs_a;
            k_a++;
        end
    end

    always @(posedge clk or negedge rst_b_n) begin
        if (!rst_b_n) begin
            k_b = 0; mfs_b = 1'b0; mack_b = 1'b0;
        end else begin
            mack_b = ((k_b % (htot(cfg_b) * vtot(cfg_b))) == cfg_b.vvis * htot(cfg_b)) && swap_b;
            if (mack_b) mfs_b = ~mfs_b;
            k_b++;
        end
    end

    always @(negedge clk) begin : compare
        chk("a_cycle", vec_a, expect_vec(cfg_a, k_a, mfs_a, mack_a));
        chk("b_cycle", vec_b, expect_vec(cfg_b, k_b, mfs_b, mack_b));
        if (n_fail >= 200) begin
            $display("FAIL abort: too many mismatches");
            finish_run();
        end
    end

    task automatic wait_k(input bit sel_b, input int n);
        while ((sel_b ? k_b : k_a) < n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : seq_a
        int g, fall1;
        #1 rst_a_n = 1'b0;
        repeat (10) @(negedge clk);
        chk("a_reset_state", vec_a, 32'h0000_C000);
        #2 rst_a_n = 1'b1;

        g = 0;
        while (hsync_a && g < 2000) begin @(posedge clk); #1; g++; end
        chk("a_first_hsync_fall", k_a, 658);
        fall1 = k_a;
        g = 0;
        while (!hsync_a && g < 2000) begin @(posedge clk); #1; g++; end
        chk("a_hsync_low_width", k_a - fall1, 96);
        g = 0;
        while (hsync_a && g < 2000) begin @(posedge clk); #1; g++; end
        chk("a_hsync_period", k_a - fall1, 800);

        wait_k(1'b0, 8101);
        chk("a_letterbox_line10", {read_addr_a, r_a, g_a, b_a}, 26'd0);

        g = 0;
        while (!fs_a && g < 20000) begin @(posedge clk); #1; g++; end
        chk("a_frame_start_latency", k_a, 12802);

        wait_k(1'b0, 12808);
        chk("a_addr_col1_row0", read_addr_a, 14'd64);
        wait_k(1'b0, 18240);
        chk("a_addr_col127_row0", read_addr_a, 14'd8128);
        wait_k(1'b0, 18401);
        chk("a_addr_col0_row1", read_addr_a, 14'd1);
        @(posedge clk); #1;
        chk("a_rgb_col0_row1", {r_a, g_a, b_a}, 12'h001);
        done_a = 1'b1;
    end

    initial begin : seq_b
        int g, acks, ack1_k, ack2_k;
        logic fsel_after1;
        #1 rst_b_n = 1'b0;
        repeat (10) @(negedge clk);
        chk("b_reset_state", vec_b, 32'h0000_C000);
        #2 rst_b_n = 1'b1;

        wait_k(1'b1, 5000);
        swap_b = 1'b1;
        wait_k(1'b1, 9776);
        chk("b_last_pixel_addr", read_addr_b, 14'd8191);
        chk("b_no_early_swap", frame_sel_b, 1'b0);

        g = 0;
        while (!swap_ack_b && g < 12000) begin @(posedge clk); #1; g++; end
        chk("b_swap_ack_time", k_b, 10369);
        chk("b_swap_toggled", frame_sel_b, 1'b1);
        swap_b = 1'b0;

        g = 0;
        while (vsync_b && g < 12000) begin @(posedge clk); #1; g++; end
        chk("b_vsync_fall", k_b, 10658);
        g = 0;
        while (!vsync_b && g < 12000) begin @(posedge clk); #1; g++; end
        chk("b_vsync_low_width", k_b - 10658, 288);

        wait_k(1'b1, 20016);
        chk("b_fsel_before_reset", frame_sel_b, 1'b1);
        @(negedge clk);
        #2 rst_b_n = 1'b0;
        #1 chk("b_midframe_reset", vec_b, 32'h0000_C000);
        repeat (10) @(negedge clk);
        #2 rst_b_n = 1'b1;
        g = 0;
        while (!fs_b && g < 5000) begin @(posedge clk); #1; g++; end
        chk("b_frame_start_after_reset", k_b, 578);

        swap_b = 1'b1;
        acks = 0; ack1_k = 0; ack2_k = 0; fsel_after1 = 1'b0;
        while (k_b < 22952) begin
            @(posedge clk); #1;
            if (swap_ack_b) begin
                acks++;
                if (acks == 1) begin ack1_k = k_b; fsel_after1 = frame_sel_b; end
                if (acks == 2) begin ack2_k = k_b; swap_b = 1'b0; end
            end
        end
        chk("b_held_swap_count", acks, 2);
        chk("b_held_swap_first", ack1_k, 10369);
        chk("b_held_swap_second", ack2_k, 21745);
        chk("b_held_swap_fsel1", fsel_after1, 1'b1);
        chk("b_held_swap_fsel2", frame_sel_b, 1'b0);
        done_b = 1'b1;
    end

    initial begin : supervisor
        fork
            begin
                wait (done_a && done_b);
                repeat (3) @(negedge clk);
            end
            begin
                #1_500_000;
                n_fail++;
                $display("FAIL timeout: sequences did not complete");
            end
        join_any
        finish_run();
    end
endmodule
